// File: rtl/aes_stream_gearbox.sv
// aes_stream_gearbox: packs NW stream words into one block for the AES core and unpacks result blocks into words.
// Latency: packed block valid 1 cycle after the last input word; first output word valid 1 cycle after the result transfer.
// Backpressure: one block buffered per side; in_ready_o / res_ready_o drop while that side's buffer is occupied.
module aes_stream_gearbox #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                byte_swap_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_W-1:0]   in_data_i,
  output logic                blk_valid_o,
  input  logic                blk_ready_i,
  output logic [BLOCK_W-1:0]  blk_data_o,
  input  logic                res_valid_i,
  output logic                res_ready_o,
  input  logic [BLOCK_W-1:0]  res_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [DATA_W/8-1:0] out_strb_o,
  output logic [CNT_W-1:0]    blk_cnt_o,
  output logic                busy_o
);

  localparam int NW    = BLOCK_W / DATA_W;
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  // Reverse the byte order of one stream word.
  function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) begin
      r[b*8 +: 8] = w[(NB-1-b)*8 +: 8];
    end
    return r;
  endfunction

  // Input (pack) side state
  logic               in_full_q, in_full_d;
  logic [IDX_W-1:0]   wcnt_q, wcnt_d;
  logic [BLOCK_W-1:0] pack_q, pack_d;

  // Output (unpack) side state
  logic               res_full_q, res_full_d;
  logic [IDX_W-1:0]   rcnt_q, rcnt_d;
  logic [BLOCK_W-1:0] unpack_q, unpack_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

  logic               busy_q, busy_d;

  // Handshake events; each side's buffer is single-entry so capture and release never coincide on one side.
  logic              in_xfer;
  logic              blk_xfer;
  logic              res_xfer;
  logic              out_xfer;
  logic [DATA_W-1:0] in_word;
  logic [DATA_W-1:0] out_word_raw;

  assign in_xfer  = in_valid_i  && !in_full_q;
  assign blk_xfer = blk_valid_o && blk_ready_i;
  assign res_xfer = res_valid_i && !res_full_q;
  assign out_xfer = out_valid_o && out_ready_i;

  assign in_word      = byte_swap_i ? swap_bytes(in_data_i) : in_data_i;
  assign out_word_raw = unpack_q[rcnt_q*DATA_W +: DATA_W];

  // Pack side next state: collect words at wcnt, mark the block full on the last one, release on core accept.
  always_comb begin
    in_full_d = in_full_q;
    wcnt_d    = wcnt_q;
    pack_d    = pack_q;
    if (blk_xfer) begin
      in_full_d = 1'b0;
    end
    if (in_xfer) begin
      pack_d[wcnt_q*DATA_W +: DATA_W] = in_word;
      if (wcnt_q == LAST_IDX) begin
        in_full_d = 1'b1;
        wcnt_d    = '0;
      end else begin
        wcnt_d = wcnt_q + IDX_W'(1);
      end
    end
    if (clear_i) begin
      in_full_d = 1'b0;
      wcnt_d    = '0;
      pack_d    = '0;
    end
  end

  // Unpack side next state: capture a result block, step through its words, count fully emitted blocks.
  always_comb begin
    res_full_d = res_full_q;
    rcnt_d     = rcnt_q;
    unpack_d   = unpack_q;
    blk_cnt_d  = blk_cnt_q;
    if (out_xfer) begin
      if (rcnt_q == LAST_IDX) begin
        res_full_d = 1'b0;
        rcnt_d     = '0;
        blk_cnt_d  = blk_cnt_q + CNT_W'(1);
      end else begin
        rcnt_d = rcnt_q + IDX_W'(1);
      end
    end
    if (res_xfer) begin
      unpack_d   = res_data_i;
      res_full_d = 1'b1;
      rcnt_d     = '0;
    end
    if (clear_i) begin
      res_full_d = 1'b0;
      rcnt_d     = '0;
      unpack_d   = '0;
      blk_cnt_d  = '0;
    end
  end

  // Busy is registered but computed from next state so it tracks the held-data condition without lag.
  always_comb begin
    busy_d = in_full_d | res_full_d | (wcnt_d != '0);
  end

  // Pack side registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_full_q <= 1'b0;
      wcnt_q    <= '0;
      pack_q    <= '0;
    end else begin
      in_full_q <= in_full_d;
      wcnt_q    <= wcnt_d;
      pack_q    <= pack_d;
    end
  end

  // Unpack side registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_full_q <= 1'b0;
      rcnt_q     <= '0;
      unpack_q   <= '0;
      blk_cnt_q  <= '0;
    end else begin
      res_full_q <= res_full_d;
      rcnt_q     <= rcnt_d;
      unpack_q   <= unpack_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  // Busy flag register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign in_ready_o  = !in_full_q;
  assign blk_valid_o = in_full_q;
  assign blk_data_o  = pack_q;
  assign res_ready_o = !res_full_q;
  assign out_valid_o = res_full_q;
  assign out_data_o  = byte_swap_i ? swap_bytes(out_word_raw) : out_word_raw;
  assign out_strb_o  = '1;
  assign blk_cnt_o   = blk_cnt_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_aes_stream_gearbox.sv
module tb_aes_stream_gearbox;

  localparam int DW = 32;
  localparam int BW = 128;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic          byte_swap_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          blk_valid_o;
  logic          blk_ready_i;
  logic [BW-1:0] blk_data_o;
  logic          res_valid_i;
  logic          res_ready_o;
  logic [BW-1:0] res_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [3:0]    out_strb_o;
  logic [CW-1:0] blk_cnt_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  aes_stream_gearbox #(.DATA_W(DW), .BLOCK_W(BW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .byte_swap_i(byte_swap_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .blk_data_o(blk_data_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_strb_o(out_strb_o), .blk_cnt_o(blk_cnt_o), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int out_words = 0;

  logic [BW-1:0] blkq[$];
  logic [DW-1:0] outq[$];
  logic [BW-1:0] mon_blk_e;
  logic [DW-1:0] mon_out_e;

  typedef struct {
    logic            sw;
    logic [3:0][31:0] w;
    logic [BW-1:0]   exp_blk;
  } vec_t;
  vec_t vecs[3];

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = w;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!in_ready_o) fail("in_handshake");
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_res(input logic [BW-1:0] d);
    int n;
    n = 0;
    res_valid_i = 1'b1;
    res_data_i  = d;
    for (int k = 0; k < 4; k++) begin
      outq.push_back(byte_swap_i ? bswap(d[k*32 +: 32]) : d[k*32 +: 32]);
    end
    @(negedge clk_i);
    while (!res_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!res_ready_o) fail("res_handshake");
    @(posedge clk_i);
    #1;
    res_valid_i = 1'b0;
  endtask

  task automatic wait_blk_empty(input string name);
    int n;
    n = 0;
    while (blkq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (blkq.size() != 0) fail(name);
  endtask

  task automatic wait_out_empty(input string name);
    int n;
    n = 0;
    while (outq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (outq.size() != 0) fail(name);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_in_ready"},  BW'(in_ready_o),  BW'(1));
    check({p, "_res_ready"}, BW'(res_ready_o), BW'(1));
    check({p, "_blk_valid"}, BW'(blk_valid_o), BW'(0));
    check({p, "_out_valid"}, BW'(out_valid_o), BW'(0));
    check({p, "_blk_cnt"},   BW'(blk_cnt_o),   BW'(0));
    check({p, "_busy"},      BW'(busy_o),      BW'(0));
    check({p, "_strb"},      BW'(out_strb_o),  BW'(4'hF));
    check({p, "_blk_data"},  blk_data_o,       BW'(0));
    check({p, "_out_data"},  BW'(out_data_o),  BW'(0));
  endtask

  // Scoreboard monitor: transfers are decided at the falling edge, inputs being stable then.
  always @(negedge clk_i) begin
    if (!rst_i && !clear_i) begin
      if (blk_valid_o && blk_ready_i) begin
        if (blkq.size() == 0) begin
          check("blk_unexpected", blk_data_o, BW'(0));
        end else begin
          mon_blk_e = blkq.pop_front();
          check("blk_data", blk_data_o, mon_blk_e);
        end
      end
      if (out_valid_o && out_ready_i) begin
        out_words++;
        if (outq.size() == 0) begin
          check("out_unexpected", BW'(out_data_o), BW'(0));
        end else begin
          mon_out_e = outq.pop_front();
          check("out_data", BW'(out_data_o), BW'(mon_out_e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] hold;
    int base_words;

    vecs[0] = '{1'b0, {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100},
                128'h0F0E0D0C_0B0A0908_07060504_03020100};
    vecs[1] = '{1'b1, {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233},
                128'hFFEEDDCC_BBAA9988_77665544_33221100};
    vecs[2] = '{1'b0, {32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF},
                128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF};

    rst_i = 1'b1; clear_i = 1'b0; byte_swap_i = 1'b0;
    in_valid_i = 1'b0; in_data_i = '0; blk_ready_i = 1'b0;
    res_valid_i = 1'b0; res_data_i = '0; out_ready_i = 1'b0;
    #3;
    check_reset_outputs("reset");
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // Pack with the core stalled, then hold the block for 5 cycles.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        check("pre_last_blk_valid", BW'(blk_valid_o), BW'(0));
        blkq.push_back(vecs[0].exp_blk);
      end
      send_word(vecs[0].w[k]);
    end
    check("blk_valid_after_last", BW'(blk_valid_o), BW'(1));
    check("blk_data_after_last", blk_data_o, vecs[0].exp_blk);
    check("busy_full", BW'(busy_o), BW'(1));
    for (int c = 0; c < 5; c++) begin
      check("stall_in_ready", BW'(in_ready_o), BW'(0));
      check("stall_blk_data", blk_data_o, vecs[0].exp_blk);
      tick();
    end
    blk_ready_i = 1'b1;
    tick();
    check("release_in_ready", BW'(in_ready_o), BW'(1));
    check("release_blk_valid", BW'(blk_valid_o), BW'(0));
    check("release_queue", BW'(blkq.size()), BW'(0));

    // Table-driven pack vectors.
    for (int v = 0; v < 3; v++) begin
      byte_swap_i = vecs[v].sw;
      do_clear();
      for (int k = 0; k < 4; k++) begin
        if (k == 3) blkq.push_back(vecs[v].exp_blk);
        send_word(vecs[v].w[k]);
      end
      wait_blk_empty("table_blk");
    end

    // Unpack with byte swap; first word checked while output is stalled.
    byte_swap_i = 1'b1;
    do_clear();
    out_ready_i = 1'b0;
    send_res(128'h8899AABB_44556677_CCDDEEFF_00112233);
    check("first_out_valid", BW'(out_valid_o), BW'(1));
    check("first_out_word", BW'(out_data_o), BW'(32'h33221100));
    tick();
    check("first_out_held", BW'(out_data_o), BW'(32'h33221100));
    out_ready_i = 1'b1;
    wait_out_empty("swap_out");
    check("swap_blk_cnt", BW'(blk_cnt_o), BW'(1));
    check("swap_out_valid", BW'(out_valid_o), BW'(0));
    check("swap_busy", BW'(busy_o), BW'(0));

    // Three back-to-back result blocks under random output back-pressure.
    byte_swap_i = 1'b0;
    do_clear();
    out_ready_i = 1'b0;
    base_words = out_words;
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int b = 0; b < 3; b++) send_res({$urandom, $urandom, $urandom, $urandom});
          done = 1'b1;
        end
        begin
          int n;
          n = 0;
          while (!(done && outq.size() == 0) && n < 600) begin
            tick();
            out_ready_i = 1'($urandom_range(0, 1));
            n++;
          end
        end
      join
    end
    out_ready_i = 1'b0;
    check("bp_queue_empty", BW'(outq.size()), BW'(0));
    check("bp_word_count", BW'(out_words - base_words), BW'(12));
    check("bp_blk_cnt", BW'(blk_cnt_o), BW'(3));

    // Clear after two of four input words drops the partial block.
    do_clear();
    blk_ready_i = 1'b1;
    send_word(32'hAAAA0001);
    send_word(32'hAAAA0002);
    check("partial_busy", BW'(busy_o), BW'(1));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear_busy", BW'(busy_o), BW'(0));
    check("clear_in_ready", BW'(in_ready_o), BW'(1));
    check("clear_blk_valid", BW'(blk_valid_o), BW'(0));
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    blkq.push_back(128'h44444444_33333333_22222222_11111111);
    send_word(32'h44444444);
    wait_blk_empty("clean_blk");

    // Counter wrap over 16 blocks.
    do_clear();
    out_ready_i = 1'b1;
    for (int b = 0; b < 16; b++) begin
      send_res({$urandom, $urandom, $urandom, $urandom});
      wait_out_empty("wrap_out");
      if (b == 14) check("cnt_15", BW'(blk_cnt_o), BW'(15));
    end
    check("cnt_wrap", BW'(blk_cnt_o), BW'(0));

    // Asynchronous reset in the middle of a block on both sides.
    out_ready_i = 1'b0;
    blk_ready_i = 1'b0;
    send_word(32'h5555AAAA);
    send_word(32'h6666BBBB);
    send_res(128'h01020304_05060708_090A0B0C_0D0E0F10);
    check("pre_rst_busy", BW'(busy_o), BW'(1));
    check("pre_rst_out_valid", BW'(out_valid_o), BW'(1));
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("midrst");
    outq.delete();
    blkq.delete();
    tick();
    rst_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
